// File: rtl/event_profiler_if.sv
// Snapshot handoff bundle between the event profiler and its readout consumer.
// master = profiler (drives data/valid), slave = consumer (drives ready).
interface event_profiler_if #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32
);
    logic                    snap_valid;
    logic                    snap_ready;
    logic [NUM_CH*CNT_W-1:0] snap_counts;
    logic [NUM_CH-1:0]       snap_ovf;
    logic [15:0]             snap_seq;
    logic [15:0]             snap_drop_cnt;

    modport master (
        output snap_valid,
        output snap_counts,
        output snap_ovf,
        output snap_seq,
        output snap_drop_cnt,
        input  snap_ready
    );

    modport slave (
        input  snap_valid,
        input  snap_counts,
        input  snap_ovf,
        input  snap_seq,
        input  snap_drop_cnt,
        output snap_ready
    );
endinterface

// File: rtl/event_profiler.sv
// N-channel event profiler: per-channel saturating edge/level counters, periodic or
// requested snapshots, handed off through a one-entry valid/ready buffer.
module event_profiler #(
    parameter int NUM_CH        = 8,
    parameter int CNT_W         = 32,
    parameter int SAMPLE_PERIOD = 1000000,
    parameter int CLEAR_ON_SNAP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic [NUM_CH-1:0] ch_mode_i,
    input  logic [NUM_CH-1:0] ch_event_i,
    input  logic              snap_req_i,
    event_profiler_if.master  snap_if
);
    localparam int               TMR_W    = $clog2(SAMPLE_PERIOD);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
        return v;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [CNT_W-1:0]        cnt_q [NUM_CH];
    logic [CNT_W-1:0]        cnt_d [NUM_CH];
    logic [NUM_CH-1:0]       ovf_q, ovf_d;
    logic [NUM_CH-1:0]       prev_q;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic                    vld_q, vld_d;
    logic [NUM_CH*CNT_W-1:0] hcnt_q, hcnt_d;
    logic [NUM_CH-1:0]       hovf_q, hovf_d;
    logic [15:0]             seq_q, seq_d;
    logic [15:0]             drop_q, drop_d;

    logic [NUM_CH-1:0]       inc;
    logic                    trig;
    logic                    accept;
    logic                    load;
    logic [NUM_CH*CNT_W-1:0] cap_cnt;
    logic [NUM_CH-1:0]       cap_ovf;

    // prev_q tracks the line even while disabled, so enabling on a high line is not an edge
    assign inc    = {NUM_CH{enable_i}} &
                    ((ch_mode_i & ch_event_i) | (~ch_mode_i & ch_event_i & ~prev_q));
    assign trig   = (enable_i && (tmr_q == TMR_LAST)) || snap_req_i;
    assign accept = vld_q && snap_if.snap_ready;
    assign load   = trig && (!vld_q || accept);

    // Captured value includes this cycle's increment so nothing is lost at the boundary
    always_comb begin
        cap_cnt = '0;
        cap_ovf = ovf_q;
        for (int k = 0; k < NUM_CH; k++) begin
            cap_cnt[k*CNT_W +: CNT_W] = sat_inc(cnt_q[k], inc[k]);
            if (inc[k] && (cnt_q[k] == {CNT_W{1'b1}})) cap_ovf[k] = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) cnt_d[k] = cap_cnt[k*CNT_W +: CNT_W];
        ovf_d  = cap_ovf;
        tmr_d  = tmr_q;
        vld_d  = vld_q;
        hcnt_d = hcnt_q;
        hovf_d = hovf_q;
        seq_d  = seq_q;
        drop_d = drop_q;

        if (snap_req_i) begin
            tmr_d = '0;
        end else if (enable_i) begin
            tmr_d = (tmr_q == TMR_LAST) ? '0 : tmr_q + TMR_W'(1);
        end

        // Interval mode restarts the live counters even if the snapshot is dropped
        if (trig && (CLEAR_ON_SNAP != 0)) begin
            for (int k = 0; k < NUM_CH; k++) cnt_d[k] = '0;
            ovf_d = '0;
        end

        if (load) begin
            hcnt_d = cap_cnt;
            hovf_d = cap_ovf;
            vld_d  = 1'b1;
            seq_d  = seq_q + 16'd1;
        end else begin
            if (trig)   drop_d = sat_inc16(drop_q);
            if (accept) vld_d  = 1'b0;
        end

        if (clear_i) begin
            for (int k = 0; k < NUM_CH; k++) cnt_d[k] = '0;
            ovf_d  = '0;
            tmr_d  = '0;
            vld_d  = 1'b0;
            seq_d  = '0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
            ovf_q  <= '0;
            prev_q <= '0;
            tmr_q  <= '0;
            vld_q  <= 1'b0;
            hcnt_q <= '0;
            hovf_q <= '0;
            seq_q  <= '0;
            drop_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
            ovf_q  <= ovf_d;
            prev_q <= ch_event_i;
            tmr_q  <= tmr_d;
            vld_q  <= vld_d;
            hcnt_q <= hcnt_d;
            hovf_q <= hovf_d;
            seq_q  <= seq_d;
            drop_q <= drop_d;
        end
    end

    assign snap_if.snap_valid    = vld_q;
    assign snap_if.snap_counts   = hcnt_q;
    assign snap_if.snap_ovf      = hovf_q;
    assign snap_if.snap_seq      = seq_q;
    assign snap_if.snap_drop_cnt = drop_q;
endmodule
